dt_skeleton: RTL and testbench
==============================

DT_SKELETON -- requirements
Module: dt_skeleton

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  single-cycle pulse from the distance-transform stage when its result map is complete.
REQ-004 busy  output  1  high from the cycle after start is accepted until done rises.
REQ-005 done  output  1  high when the scan is complete; held until the next accepted start.
REQ-006 res_rd  output  1  read strobe to the distance result RAM.
REQ-007 res_addr  output  14  result RAM address, row-major: r*128+c.
REQ-008 res_di  input  8  result RAM data; valid on the rising edge after res_addr/res_rd are presented (1-cycle latency).
REQ-009 ske_wr  output  1  single-cycle write strobe to the skeleton RAM.
REQ-010 ske_addr  output  10  skeleton word address: r*8+c/16.
REQ-011 ske_do  output  16  packed skeleton bits; bit 15 = leftmost pixel of the 16-pixel group.
REQ-012 max_dist  output  8  largest distance value read in the current scan.
REQ-013 ske_count  output  15  number of skeleton pixels found in the current scan.

Function
REQ-014 Image size is 128x128 pixels; the skeleton pixel flag is 1 if P>0 and P>=N, P>=S, P>=W and P>=E; otherwise it is 0.
REQ-015 Neighbours outside the image are 0.
REQ-016 FSM states: IDLE, FILL, RUN, FLUSH, FIN; reset enters IDLE.
REQ-017 IDLE: start=1 moves to FILL, clears max_dist, ske_count and the packing register, and deasserts done.
REQ-018 FILL/RUN: res_rd=1 with res_addr advancing by 1 every cycle, from 0 to 16383, without gaps.
REQ-019 Two 128x8 line buffers hold rows r-1 and r; the incoming row r+1 pixel c supplies S for pixel (r,c), which is evaluated in the cycle its S value arrives.
REQ-020 FILL lasts while row 0 is returning; no evaluation occurs in FILL; the block moves to RUN when the row-0 data is complete.
REQ-021 FLUSH: res_rd=0 for 128 cycles; row 127 is evaluated with S=0.
REQ-022 Evaluated flags shift into bit (15 - c mod 16) of the packing register.
REQ-023 On the 16th pixel of a group, ske_wr=1 for one cycle with the completed word, and the register clears.
REQ-024 Exactly 1024 writes occur per scan, to addresses 0..1023 in ascending order.
REQ-025 After the write to address 1023, the block enters FIN, asserts done on the next cycle, and returns to IDLE.
REQ-026 Total cycles from start sampled to done high SHALL NOT exceed 16520.
REQ-027 start received while busy=1 is ignored.
REQ-028 max_dist is an unsigned 8-bit compare-and-hold; ske_count increments by 1 per flag=1, with no saturation needed because its maximum is 16384.
REQ-029 res_rd, ske_wr, busy and done are registered, and no output glitches mid-cycle.

Reset
REQ-030 reset=0 forces, asynchronously: state=IDLE, busy=0, done=0, res_rd=0, res_addr=0, ske_wr=0, ske_addr=0, ske_do=0, max_dist=0, ske_count=0.
REQ-031 Line buffer contents are not reset; they are fully rewritten before they are read.
REQ-032 A reset during a scan aborts it; skeleton RAM writes already issued are not undone, and a new start is required.

Configuration
REQ-033 Macro DT_SKELETON_STATS_EN.
REQ-034 With DT_SKELETON_STATS_EN defined, max_dist and ske_count are tracked per REQ-028.
REQ-035 Without DT_SKELETON_STATS_EN, max_dist and ske_count are tied to 0, their registers are not synthesized, and the skeleton output is unchanged.

Verification
REQ-036 All-zero map, start -> 1024 writes of 0x0000, done=1, ske_count=0, max_dist=0.
REQ-037 Single pixel value 3 at (5,7), all other pixels 0 -> word 40 = 0x0100, all other words 0x0000, ske_count=1, max_dist=3.
REQ-038 All pixels = 1 -> every word 0xFFFF, ske_count=16384, max_dist=1.
REQ-039 Map value = c+1 (column ramp) -> words r*8+7 = 0x0001, all other words 0x0000, ske_count=128, max_dist=128.
REQ-040 Second start pulse during busy -> ignored; exactly 1024 writes; done rises within 16520 cycles.
REQ-041 reset=0 at cycle 5000 of a scan -> all outputs at reset values immediately; after a new start, the REQ-038 result is reproduced in full.

Source files
------------

// File: rtl/dt_skeleton.sv
// Skeleton extraction over a 128x128 distance map: streams the result RAM once,
// flags local maxima and packs them 16 per word into the skeleton RAM.
// Optional statistics (max_dist, ske_count) are enabled by DT_SKELETON_STATS_EN.
module dt_skeleton (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        ske_wr,
  output logic [9:0]  ske_addr,
  output logic [15:0] ske_do,
  output logic [7:0]  max_dist,
  output logic [14:0] ske_count
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, FIN} state_t;

  state_t      state_q;
  logic        busy_q, done_q, res_rd_q, vld_q, ske_wr_q;
  logic [13:0] res_addr_q, in_cnt_q;
  logic [9:0]  ske_addr_q;
  logic [15:0] ske_do_q, pack_q, pack_d;
  logic [7:0]  w_q;
  logic [7:0]  lb_up_q  [128];
  logic [7:0]  lb_cur_q [128];

  logic [6:0]  col, colp1, erow;
  logic [7:0]  pix_p, pix_n, pix_s, pix_w, pix_e;
  logic        eval, flag;

  // in_cnt counts returned pixels; during FLUSH it wraps to row 0, so row-1 yields 127
  always_comb begin
    col   = in_cnt_q[6:0];
    colp1 = col + 7'd1;
    erow  = in_cnt_q[13:7] - 7'd1;
    pix_p = lb_cur_q[col];
    pix_n = (erow == 7'd0) ? '0 : lb_up_q[col];
    pix_s = (state_q == RUN) ? res_di : '0;
    pix_w = (col == 7'd0) ? '0 : w_q;
    pix_e = (col == 7'd127) ? '0 : lb_cur_q[colp1];
    eval  = ((state_q == RUN) && vld_q) || (state_q == FLUSH);
    flag  = (pix_p != 8'd0) && (pix_p >= pix_n) && (pix_p >= pix_s) &&
            (pix_p >= pix_w) && (pix_p >= pix_e);
    pack_d = {pack_q[14:0], flag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      vld_q      <= 1'b0;
      in_cnt_q   <= '0;
      ske_wr_q   <= 1'b0;
      ske_addr_q <= '0;
      ske_do_q   <= '0;
      pack_q     <= '0;
      w_q        <= '0;
    end else begin
      ske_wr_q <= 1'b0;
      vld_q    <= res_rd_q;
      if (res_rd_q) begin
        res_addr_q <= res_addr_q + 14'd1;
        if (res_addr_q == 14'h3FFF) res_rd_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q    <= FILL;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
          res_rd_q   <= 1'b1;
          res_addr_q <= '0;
          in_cnt_q   <= '0;
          pack_q     <= '0;
        end
        FILL: if (vld_q) begin
          in_cnt_q <= in_cnt_q + 14'd1;
          if (col == 7'd127) state_q <= RUN;
        end
        RUN: if (vld_q) begin
          in_cnt_q <= in_cnt_q + 14'd1;
          if (in_cnt_q == 14'h3FFF) state_q <= FLUSH;
        end
        FLUSH: begin
          in_cnt_q <= in_cnt_q + 14'd1;
          if (col == 7'd127) state_q <= FIN;
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (eval) begin
        w_q <= pix_p;
        if (col[3:0] == 4'hF) begin
          ske_wr_q   <= 1'b1;
          ske_do_q   <= pack_d;
          ske_addr_q <= {erow, col[6:4]};
          pack_q     <= '0;
        end else begin
          pack_q <= pack_d;
        end
      end
    end
  end

  // Row r+1 pixel replaces row r at the same column only after (r,c) has read it
  always_ff @(posedge clk) begin
    if (((state_q == FILL) || (state_q == RUN)) && vld_q) begin
      lb_up_q[col]  <= lb_cur_q[col];
      lb_cur_q[col] <= res_di;
    end
  end

`ifdef DT_SKELETON_STATS_EN
  logic [7:0]  max_q;
  logic [14:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
      cnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      if (((state_q == FILL) || (state_q == RUN)) && vld_q && (res_di > max_q))
        max_q <= res_di;
      if (eval && flag) cnt_q <= cnt_q + 15'd1;
    end
  end

  assign max_dist  = max_q;
  assign ske_count = cnt_q;
`else
  assign max_dist  = '0;
  assign ske_count = '0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign ske_wr   = ske_wr_q;
  assign ske_addr = ske_addr_q;
  assign ske_do   = ske_do_q;

endmodule

// File: tb/tb_dt_skeleton.sv
// Bench for dt_skeleton: table of image patterns with hand-computed skeleton words,
// plus sequences for a repeated start during busy and a reset in mid-scan.
module tb_dt_skeleton;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, res_rd, ske_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_di = '0;
  logic [9:0]  ske_addr;
  logic [15:0] ske_do;
  logic [7:0]  max_dist;
  logic [14:0] ske_count;

  dt_skeleton dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .ske_wr(ske_wr), .ske_addr(ske_addr), .ske_do(ske_do),
    .max_dist(max_dist), .ske_count(ske_count)
  );

  always #5 clk = ~clk;

  logic [7:0]  img [16384];
  logic [15:0] wlog [1024];
  int          wcnt = 0;
  int          order_err = 0;
  int          checks = 0;
  int          errors = 0;

  // Result RAM with one cycle of read latency
  always @(posedge clk) if (res_rd) res_di <= img[res_addr];

  always @(negedge clk) begin
    if (ske_wr) begin
      if (int'(ske_addr) != wcnt) order_err++;
      if (wcnt < 1024) wlog[wcnt] = ske_do;
      wcnt++;
    end
  end

  typedef struct {
    int          pat;
    logic [15:0] def_w;
    int          sp_step;
    int          sp_off;
    logic [15:0] sp_w;
    int          one_addr;
    logic [15:0] one_w;
    int          exp_cnt;
    int          exp_max;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 16384; i++) img[i] = 8'd0;
    case (pat)
      1: img[5*128+7] = 8'd3;
      2: for (int i = 0; i < 16384; i++) img[i] = 8'd1;
      3: for (int i = 0; i < 16384; i++) img[i] = 8'((i % 128) + 1);
      4: begin img[0] = 8'd5; img[16383] = 8'd5; end
      5: begin img[64*128] = 8'd4; img[64*128+1] = 8'd9; end
      6: begin img[10*128+20] = 8'd2; img[10*128+21] = 8'd2; end
      default: ;
    endcase
  endtask

  task automatic run_scan(input bit dbl_start, output int cyc);
    wcnt = 0;
    order_err = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20000) begin
      if (cyc == 100 && dbl_start) start = 1'b1;
      if (cyc == 101) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    cyc = cyc - 1;
  endtask

  task automatic check_scan(input vec_t v, input int cyc, input string tag);
    int bad, first_bad;
    logic [15:0] ew;
    bad = 0;
    first_bad = -1;
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cycles_le_16520"}, int'(cyc <= 16520), 1);
    chk({tag, "_writes"}, wcnt, 1024);
    chk({tag, "_order_err"}, order_err, 0);
    for (int a = 0; a < 1024; a++) begin
      ew = v.def_w;
      if (v.sp_step != 0 && (a % v.sp_step) == v.sp_off) ew = v.sp_w;
      if (a == v.one_addr) ew = v.one_w;
      if (a < wcnt && wlog[a] !== ew) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = a;
          $display("word %0d got %h want %h", a, wlog[a], ew);
        end
      end
    end
    chk({tag, "_bad_words"}, bad, 0);
`ifdef DT_SKELETON_STATS_EN
    chk({tag, "_ske_count"}, int'(ske_count), v.exp_cnt);
    chk({tag, "_max_dist"}, int'(max_dist), v.exp_max);
`else
    chk({tag, "_ske_count"}, int'(ske_count), 0);
    chk({tag, "_max_dist"}, int'(max_dist), 0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_res_rd"}, int'(res_rd), 0);
    chk({tag, "_res_addr"}, int'(res_addr), 0);
    chk({tag, "_ske_wr"}, int'(ske_wr), 0);
    chk({tag, "_ske_addr"}, int'(ske_addr), 0);
    chk({tag, "_ske_do"}, int'(ske_do), 0);
    chk({tag, "_max_dist"}, int'(max_dist), 0);
    chk({tag, "_ske_count"}, int'(ske_count), 0);
  endtask

  initial begin
    int cyc;
    //         pat def      step  off  sp_w     one  one_w    cnt    max
    tbl[0] = '{0, 16'h0000, 0,    0,   16'h0000, -1, 16'h0000, 0,     0};
    tbl[1] = '{1, 16'h0000, 0,    0,   16'h0000, 40, 16'h0100, 1,     3};
    tbl[2] = '{2, 16'hFFFF, 0,    0,   16'h0000, -1, 16'h0000, 16384, 1};
    tbl[3] = '{3, 16'h0000, 8,    7,   16'h0001, -1, 16'h0000, 128,   128};
    tbl[4] = '{4, 16'h0000, 1024, 1023, 16'h0001, 0, 16'h8000, 2,     5};
    tbl[5] = '{5, 16'h0000, 0,    0,   16'h0000, 512, 16'h4000, 1,    9};
    tbl[6] = '{6, 16'h0000, 0,    0,   16'h0000, 81, 16'h0C00, 2,     2};

    fill(0);
    #23;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_res_rd", int'(res_rd), 0);

    for (int t = 0; t < 7; t++) begin
      fill(tbl[t].pat);
      run_scan(1'b0, cyc);
      check_scan(tbl[t], cyc, $sformatf("pat%0d", tbl[t].pat));
      repeat (3) @(negedge clk);
      chk($sformatf("pat%0d_done_held", tbl[t].pat), int'(done), 1);
    end

    // Second start during busy must not restart or extend the scan
    fill(2);
    run_scan(1'b1, cyc);
    check_scan(tbl[2], cyc, "dbl_start");

    // Asynchronous reset in the middle of a scan, then a clean rerun
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5000) @(negedge clk);
    chk("mid_busy_before_reset", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_scan(1'b0, cyc);
    check_scan(tbl[2], cyc, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
